// File: rtl/i2s_tx_serf.sv
// i2s_tx_serf: I2S transmit serializer toward the CS4272 DAC, following SCLK/LRCLK generated in the clk domain.
// Define I2S_TX_MUTE_ON_UNDERRUN_EN to send silence on an underrun frame instead of repeating the last samples.
`timescale 1ns/1ps
module i2s_tx_serf #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     SCLK,
  input  logic                     LRCLK,
  input  logic signed [DATA_W-1:0] lft_in,
  input  logic signed [DATA_W-1:0] rht_in,
  input  logic                     wrt,
  output logic                     rdy,
  output logic                     frm_strt,
  output logic                     underrun,
  output logic                     SDin
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {SYNC, LFT, RHT} state_t;

  state_t                     state;
  logic                       sclk_q;
  logic                       lrclk_q;
  logic [CNT_W-1:0]           bit_cnt;
  logic signed [DATA_W-1:0]   lft_hold;
  logic signed [DATA_W-1:0]   rht_hold;
  logic signed [DATA_W-1:0]   lft_shft;
  logic signed [DATA_W-1:0]   rht_shft;
  logic                       sclk_fall;
  logic                       lrclk_fall;
  logic                       lrclk_rise;
  logic                       cur_bit;
  logic [IDX_W-1:0]           bit_idx;

  // Counter stops at SLOT_W so surplus SCLK edges never wrap into the next sample.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(SLOT_W)) ? c : c + CNT_W'(1);
  endfunction

  assign sclk_fall  = sclk_q & ~SCLK;
  assign lrclk_fall = lrclk_q & ~LRCLK;
  assign lrclk_rise = ~lrclk_q & LRCLK;

  always_comb begin
    cur_bit = 1'b0;
    bit_idx = '0;
    if (bit_cnt < CNT_W'(DATA_W)) begin
      bit_idx = IDX_W'(DATA_W - 1 - int'(bit_cnt));
      if (state == LFT)      cur_bit = lft_shft[bit_idx];
      else if (state == RHT) cur_bit = rht_shft[bit_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      state    <= SYNC;
      bit_cnt  <= '0;
      SDin     <= 1'b0;
      rdy      <= 1'b1;
      frm_strt <= 1'b0;
      underrun <= 1'b0;
      lft_hold <= '0;
      rht_hold <= '0;
      lft_shft <= '0;
      rht_shft <= '0;
    end else begin
      sclk_q   <= SCLK;
      lrclk_q  <= LRCLK;
      frm_strt <= 1'b0;
      underrun <= 1'b0;

      // Frame transfer at every left-slot start; a write in the same cycle bypasses the buffer.
      if (lrclk_fall) begin
        frm_strt <= 1'b1;
        if (wrt && rdy) begin
          lft_shft <= lft_in;
          rht_shft <= rht_in;
        end else if (!rdy) begin
          lft_shft <= lft_hold;
          rht_shft <= rht_hold;
          rdy      <= 1'b1;
        end else begin
          underrun <= 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          lft_shft <= '0;
          rht_shft <= '0;
`endif
        end
      end else if (wrt && rdy) begin
        lft_hold <= lft_in;
        rht_hold <= rht_in;
        rdy      <= 1'b0;
      end

      if (lrclk_fall)                        state <= LFT;
      else if (lrclk_rise && state == LFT)   state <= RHT;

      // The SCLK fall coinciding with the LRCLK edge is the I2S one-bit delay slot.
      if (lrclk_fall || lrclk_rise) begin
        bit_cnt <= '0;
        SDin    <= 1'b0;
      end else if (sclk_fall) begin
        SDin    <= (state == SYNC) ? 1'b0 : cur_bit;
        bit_cnt <= sat_inc(bit_cnt);
      end
    end
  end

endmodule
